// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
// Operand classes, flag bit positions, exponent bias and the canonical quiet NaN.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Exponent all-ones plus the mantissa MSB; caller slices to its word width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_mul_normalize.sv
// Combinational normalise, truncate, overflow/underflow saturation and pack of a
// raw significand product, with special-operand results taking priority.
module fp_mul_normalize
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W  = 8,
  parameter  int MAN_W  = 23,
  localparam int W      = 1 + EXP_W + MAN_W,
  localparam int PROD_W = 2 * MAN_W + 2,
  localparam int E_W    = EXP_W + 2
) (
  input  logic [PROD_W-1:0]     prod,
  input  logic signed [E_W-1:0] e,
  input  logic                  sign,
  input  fp_cls_e               cls_a,
  input  fp_cls_e               cls_b,
  input  logic                  mask_loss,
  output logic [W-1:0]          p,
  output logic [FLAG_W-1:0]     flags
);

  localparam logic [63:0]           QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]          QNAN      = QNAN_WIDE[W-1:0];
  localparam logic signed [E_W-1:0] E_INF     = E_W'((1 << EXP_W) - 1);

  logic                  msb;
  logic                  dropped;
  logic [MAN_W-1:0]      man;
  logic signed [E_W-1:0] e_adj;
  logic                  any_nan;
  logic                  any_inf;
  logic                  any_zero;

  // Returns {sticky, mantissa}: truncation toward zero of the normalised product.
  function automatic logic [MAN_W:0] round_trunc(input logic [PROD_W-1:0] pr);
    if (pr[PROD_W-1]) return {|pr[MAN_W:0], pr[2*MAN_W:MAN_W+1]};
    return {|pr[MAN_W-1:0], pr[2*MAN_W-1:MAN_W]};
  endfunction

  function automatic logic [W-1:0] sat_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] flush_zero(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  always_comb begin
    msb            = prod[PROD_W-1];
    {dropped, man} = round_trunc(prod);
    e_adj          = e + $signed({{(E_W-1){1'b0}}, msb});
    any_nan        = (cls_a == CLS_NAN) || (cls_b == CLS_NAN);
    any_inf        = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    any_zero       = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    p              = '0;
    flags          = '0;
    if (any_nan || (any_inf && any_zero)) begin
      p                   = QNAN;
      flags[FLAG_INVALID] = 1'b1;
    end else if (any_inf) begin
      p = sat_inf(sign);
    end else if (any_zero) begin
      p = flush_zero(sign);
    end else if (e_adj >= E_INF) begin
      p                    = sat_inf(sign);
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (e_adj[E_W-1] || (e_adj == '0)) begin
      p                     = flush_zero(sign);
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      p                   = {sign, e_adj[EXP_W-1:0], man};
      flags[FLAG_INEXACT] = dropped | mask_loss;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage valid/ready floating-point multiplier with optional operand mantissa
// truncation: unpack/classify, significand multiply, normalise/pack.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TRUNC = 0,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_p,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int BIAS   = fp_bias(EXP_W);
  localparam logic [SIG_W-1:0] KEEP_MASK = ~((SIG_W'(1) << TRUNC) - SIG_W'(1));

  logic adv1, adv2, adv3;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;

  logic [SIG_W-1:0]      sig_a_raw, sig_b_raw;
  logic                  sign_p1_d, sign_p1_q, sign_p2_d, sign_p2_q;
  fp_cls_e               cls_a_p1_d, cls_a_p1_q, cls_b_p1_d, cls_b_p1_q;
  fp_cls_e               cls_a_p2_d, cls_a_p2_q, cls_b_p2_d, cls_b_p2_q;
  logic [SIG_W-1:0]      sig_a_p1_d, sig_a_p1_q, sig_b_p1_d, sig_b_p1_q;
  logic signed [E_W-1:0] e_p1_d, e_p1_q, e_p2_d, e_p2_q;
  logic                  mloss_p1_d, mloss_p1_q, mloss_p2_d, mloss_p2_q;
  logic [PROD_W-1:0]     prod_p2_d, prod_p2_q;

  logic [W-1:0]          norm_p, out_p_d, out_p_q;
  logic [FLAG_W-1:0]     norm_flags, out_flags_d, out_flags_q;

  function automatic fp_cls_e classify(input logic [EXP_W-1:0] ex, input logic [MAN_W-1:0] mn);
    if (ex == '0) return CLS_ZERO;
    if (&ex) return (mn == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // A stage may load when it is empty or its successor is draining it.
  always_comb begin
    adv3     = !vld_p3_q || out_ready;
    adv2     = !vld_p2_q || adv3;
    adv1     = !vld_p1_q || adv2;
    vld_p1_d = adv1 ? in_valid : vld_p1_q;
    vld_p2_d = adv2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = adv3 ? vld_p2_q : vld_p3_q;
  end

  assign in_ready = adv1;

  // ---- stage 1: unpack, classify, mask, exponent sum ----
  always_comb begin
    sig_a_raw  = {1'b1, in_a[MAN_W-1:0]};
    sig_b_raw  = {1'b1, in_b[MAN_W-1:0]};
    sign_p1_d  = sign_p1_q;
    cls_a_p1_d = cls_a_p1_q;
    cls_b_p1_d = cls_b_p1_q;
    sig_a_p1_d = sig_a_p1_q;
    sig_b_p1_d = sig_b_p1_q;
    mloss_p1_d = mloss_p1_q;
    e_p1_d     = e_p1_q;
    if (adv1) begin
      sign_p1_d  = in_a[W-1] ^ in_b[W-1];
      cls_a_p1_d = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
      cls_b_p1_d = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
      sig_a_p1_d = sig_a_raw & KEEP_MASK;
      sig_b_p1_d = sig_b_raw & KEEP_MASK;
      mloss_p1_d = (|(sig_a_raw & ~KEEP_MASK)) | (|(sig_b_raw & ~KEEP_MASK));
      e_p1_d     = E_W'(in_a[W-2:MAN_W]) + E_W'(in_b[W-2:MAN_W]) - E_W'(BIAS);
    end
  end

  // ---- stage 2: significand multiply ----
  always_comb begin
    sign_p2_d  = sign_p2_q;
    cls_a_p2_d = cls_a_p2_q;
    cls_b_p2_d = cls_b_p2_q;
    e_p2_d     = e_p2_q;
    mloss_p2_d = mloss_p2_q;
    prod_p2_d  = prod_p2_q;
    if (adv2) begin
      sign_p2_d  = sign_p1_q;
      cls_a_p2_d = cls_a_p1_q;
      cls_b_p2_d = cls_b_p1_q;
      e_p2_d     = e_p1_q;
      mloss_p2_d = mloss_p1_q;
      prod_p2_d  = PROD_W'(sig_a_p1_q) * PROD_W'(sig_b_p1_q);
    end
  end

  // ---- stage 3: normalise and pack into the output register ----
  fp_mul_normalize #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_normalize (
    .prod     (prod_p2_q),
    .e        (e_p2_q),
    .sign     (sign_p2_q),
    .cls_a    (cls_a_p2_q),
    .cls_b    (cls_b_p2_q),
    .mask_loss(mloss_p2_q),
    .p        (norm_p),
    .flags    (norm_flags)
  );

  always_comb begin
    out_p_d     = out_p_q;
    out_flags_d = out_flags_q;
    if (adv3 && vld_p2_q) begin
      out_p_d     = norm_p;
      out_flags_d = norm_flags;
    end
  end

  assign out_valid = vld_p3_q;
  assign out_p     = out_p_q;
  assign out_flags = out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_p_q     <= '0;
      out_flags_q <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      out_p_q     <= out_p_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Interior datapath needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    sign_p1_q  <= sign_p1_d;
    cls_a_p1_q <= cls_a_p1_d;
    cls_b_p1_q <= cls_b_p1_d;
    sig_a_p1_q <= sig_a_p1_d;
    sig_b_p1_q <= sig_b_p1_d;
    mloss_p1_q <= mloss_p1_d;
    e_p1_q     <= e_p1_d;
    sign_p2_q  <= sign_p2_d;
    cls_a_p2_q <= cls_a_p2_d;
    cls_b_p2_q <= cls_b_p2_d;
    e_p2_q     <= e_p2_d;
    mloss_p2_q <= mloss_p2_d;
    prod_p2_q  <= prod_p2_d;
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: exact and TRUNC=12 instances share stimulus; results are
// scored against an arithmetic reference model plus directed handshake scenarios.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [31:0] out_p0, out_p1;
  logic [3:0]  out_flags0, out_flags1;

  int          total = 0;
  int          bad   = 0;
  logic [35:0] exp0_q[$];
  logic [35:0] exp1_q[$];
  logic [35:0] mon_e;
  logic        stall_prev = 1'b0;
  logic [31:0] p_prev;
  logic [31:0] last_p1;
  logic [3:0]  last_f1;
  logic [31:0] bp_a[6], bp_b[6];
  bit          bp_seen;
  int          guard;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TRUNC(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_p(out_p0), .out_flags(out_flags0)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TRUNC(12)) u_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_p(out_p1), .out_flags(out_flags1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: {flags[3:0], product[31:0]} from the format rules, using plain integers.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int trunc);
    int ea, eb, e, sh;
    logic s;
    bit za, zb, ia, ib, na, nb, loss, lost;
    longint ma, mb, keep, prod;
    logic [22:0] mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {4'b1000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || zb) return {4'b0000, s, 31'h0};
    keep = ~((longint'(1) << trunc) - 1);
    ma   = longint'({1'b1, a[22:0]});
    mb   = longint'({1'b1, b[22:0]});
    loss = ((ma & ~keep) != 0) || ((mb & ~keep) != 0);
    prod = (ma & keep) * (mb & keep);
    e    = ea + eb - 127;
    sh   = 23;
    if (prod >= (longint'(1) << 47)) begin
      e  = e + 1;
      sh = 24;
    end
    mant = 23'((prod >> sh) & 64'h7FFFFF);
    lost = (prod % (longint'(1) << sh)) != 0;
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, (loss || lost), s, 8'(e), mant};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[30:0] = 31'h0;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3: r[30:23] = 8'h00;
      4, 5: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // Scoreboard: outputs are checked, and accepted inputs modelled, just before the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp0_q.delete();
      exp1_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("hold_valid", out_valid0, 1);
        check_val("hold_p", out_p0, p_prev);
      end
      if (out_valid0 && out_ready) begin
        if (exp0_q.size() == 0) check_val("spurious_out0", out_valid0, 0);
        else begin
          mon_e = exp0_q.pop_front();
          check_val("p_exact", out_p0, mon_e[31:0]);
          check_val("flags_exact", out_flags0, mon_e[35:32]);
        end
      end
      if (out_valid1 && out_ready) begin
        if (exp1_q.size() == 0) check_val("spurious_out1", out_valid1, 0);
        else begin
          mon_e = exp1_q.pop_front();
          check_val("p_trunc", out_p1, mon_e[31:0]);
          check_val("flags_trunc", out_flags1, mon_e[35:32]);
        end
      end
      if (in_valid && in_ready0) begin
        exp0_q.push_back(ref_mul(in_a, in_b, 0));
        exp1_q.push_back(ref_mul(in_a, in_b, 12));
      end
      stall_prev = out_valid0 && !out_ready;
      p_prev     = out_p0;
    end
  end

  // Entered and left at posedge+1 with out_ready high.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ep, input logic [3:0] ef);
    int lat;
    bit seen;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    check_val({tag, "_in_ready"}, in_ready0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check_val({tag, "_seen"}, seen, 1);
    if (seen) begin
      check_val({tag, "_latency"}, lat, 3);
      check_val({tag, "_p"}, out_p0, ep);
      check_val({tag, "_flags"}, out_flags0, ef);
      last_p1 = out_p1;
      last_f1 = out_flags1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid0, 0);
    check_val("rst_out_p", out_p0, 0);
    check_val("rst_out_flags", out_flags0, 0);
    check_val("rst_in_ready", in_ready0, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("basic",     32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_one("neg",       32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000);
    run_one("ovf",       32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_one("unf",       32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    run_one("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one("nan",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_one("ninf",      32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_one("subnorm",   32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    run_one("approx",    32'h3F800FFF, 32'h3F800000, 32'h3F800FFF, 4'b0000);
    check_val("approx_trunc_p", last_p1, 32'h3F800000);
    check_val("approx_trunc_flags", last_f1, 4'b0001);

    // Backpressure: six back-to-back pairs, consumer stalls for five cycles.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      bp_b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    fork
      begin
        guard = 0;
        for (int i = 0; i < 6; i++) begin
          bit acc;
          in_a     = bp_a[i];
          in_b     = bp_b[i];
          in_valid = 1'b1;
          acc      = 1'b0;
          while (!acc && guard < 60) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1 guard++;
          end
        end
        in_valid = 1'b0;
        check_val("bp_feed_timeout", guard < 60, 1);
      end
      begin
        out_ready = 1'b0;
        bp_seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid0) begin
            bp_seen = 1'b1;
            break;
          end
        end
        check_val("bp_first_valid", bp_seen, 1);
        check_val("bp_in_ready_full", in_ready0, 0);
        repeat (4) begin
          @(negedge clk);
          check_val("bp_in_ready_stall", in_ready0, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check_val("bp_gapless", out_valid0, 1);
        end
      end
    join
    @(posedge clk);
    #1;

    // Reset while three operations are in flight.
    for (int i = 0; i < 3; i++) begin
      in_a     = 32'h3FC00000;
      in_b     = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid0, 0);
    check_val("midrst_out_p", out_p0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("midrst_no_stale", out_valid0, 0);
    end
    @(posedge clk);
    #1;
    run_one("post_rst", 32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000);

    // Randomised traffic with random gaps and random consumer stalls.
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_val("drain_exact", exp0_q.size(), 0);
    check_val("drain_trunc", exp1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
